// File: rtl/multi_port_axi_bridge_pkg.sv
// Shared types and AXI constants for the multi-port SRAM-to-AXI3 bridge.
package multi_port_axi_bridge_pkg;

    // Wide enough to index up to four master ports.
    localparam int PORT_IDX_W = 2;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;

    // Latched read request.
    typedef struct packed {
        logic [31:0]           addr;
        logic [1:0]            size;
        logic [PORT_IDX_W-1:0] port;
    } rd_req_t;

    // Latched write request.
    typedef struct packed {
        logic [31:0]           addr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
        logic [1:0]            size;
        logic [PORT_IDX_W-1:0] port;
    } wr_req_t;

    // Round-robin pointer successor: one past the granted port, wrapping at n.
    function automatic logic [PORT_IDX_W-1:0] rr_next(input logic [PORT_IDX_W-1:0] idx,
                                                      input int n);
        rr_next = (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/multi_port_axi_bridge_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter
    import multi_port_axi_bridge_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [PORT_IDX_W-1:0] ptr,
    output logic [N-1:0]          grant
);

    logic found;

    // Scan offsets from ptr; only the first hit gets the one-hot grant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && ((int'(ptr) + k) % N == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_port_axi_bridge.sv
// Bridges NUM_PORTS SRAM-like masters onto one AXI3 master, single-beat only.
module multi_port_axi_bridge
    import multi_port_axi_bridge_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RD_DEPTH  = 2
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS-1:0]        port_wr,
    input  logic [NUM_PORTS-1:0][1:0]   port_size,
    input  logic [NUM_PORTS-1:0][31:0]  port_addr,
    input  logic [NUM_PORTS-1:0][31:0]  port_wdata,
    input  logic [NUM_PORTS-1:0][3:0]   port_wstrb,
    output logic [NUM_PORTS-1:0]        port_addr_ok,
    output logic [NUM_PORTS-1:0]        port_data_ok,
    output logic [31:0]                 port_rdata,
    output logic [3:0]                  arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [1:0]                  arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [3:0]                  rid,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [3:0]                  awid,
    output logic [31:0]                 awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic [1:0]                  awlock,
    output logic [3:0]                  awcache,
    output logic [2:0]                  awprot,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [3:0]                  wid,
    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [3:0]                  bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready
);

    localparam int CNT_W = 3;

    ar_state_e                        ar_state, ar_state_nxt;
    w_state_e                         w_state, w_state_nxt;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  rd_cnt;
    logic [PORT_IDX_W-1:0]            rd_ptr, wr_ptr;
    rd_req_t                          rd_q, rd_sel;
    wr_req_t                          wr_q, wr_sel;
    logic                             aw_pend, w_pend;
    logic [NUM_PORTS-1:0]             rd_req, wr_req, rd_gnt, wr_gnt;
    logic [NUM_PORTS-1:0]             r_hit, b_hit;
    logic                             rd_take, wr_take, rd_outstanding;
    logic                             ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic                             unused_resp;

    // Response status and rlast carry nothing for single-beat OKAY-agnostic traffic.
    assign unused_resp = ^{rresp, bresp, rlast};

    assign rready = !reset;
    assign ar_hs  = arvalid && arready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign r_hs   = rvalid && rready;
    assign b_hs   = bvalid && bready;

    // Per-port eligibility, RAW hazard against the in-flight write, response routing.
    always_comb begin
        rd_outstanding = 1'b0;
        rd_req = '0;
        wr_req = '0;
        r_hit  = '0;
        b_hit  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_req[i] = !reset && (ar_state == AR_IDLE) && port_req[i] && !port_wr[i]
                        && (rd_cnt[i] < CNT_W'(RD_DEPTH))
                        && !((w_state != W_IDLE) && (port_addr[i][31:2] == wr_q.addr[31:2]));
            wr_req[i] = !reset && (w_state == W_IDLE) && port_req[i] && port_wr[i];
            if (rd_cnt[i] != '0) rd_outstanding = 1'b1;
            // A return for a port with nothing outstanding is stale (pre-reset) and dropped.
            r_hit[i] = r_hs && (rid == 4'(i)) && (rd_cnt[i] != '0);
            b_hit[i] = b_hs && (bid == 4'(i));
        end
        // Writes only start once every read has come back.
        if (rd_outstanding) wr_req = '0;
    end

    rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (.req(rd_req), .ptr(rd_ptr), .grant(rd_gnt));
    rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (.req(wr_req), .ptr(wr_ptr), .grant(wr_gnt));

    assign rd_take      = |rd_gnt;
    assign wr_take      = |wr_gnt;
    assign port_addr_ok = rd_gnt | wr_gnt;

    // Mux the granted port's request fields for latching.
    always_comb begin
        rd_sel = '0;
        wr_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_gnt[i]) begin
                rd_sel.addr = port_addr[i];
                rd_sel.size = port_size[i];
                rd_sel.port = PORT_IDX_W'(i);
            end
            if (wr_gnt[i]) begin
                wr_sel.addr  = port_addr[i];
                wr_sel.wdata = port_wdata[i];
                wr_sel.wstrb = port_wstrb[i];
                wr_sel.size  = port_size[i];
                wr_sel.port  = PORT_IDX_W'(i);
            end
        end
    end

    // Read FSM next state and AR valid.
    always_comb begin
        ar_state_nxt = ar_state;
        arvalid      = 1'b0;
        case (ar_state)
            AR_IDLE: if (rd_take) ar_state_nxt = AR_BUSY;
            AR_BUSY: begin
                arvalid = 1'b1;
                if (ar_hs) ar_state_nxt = AR_IDLE;
            end
            default: ar_state_nxt = AR_IDLE;
        endcase
    end

    // Write FSM next state and B ready; B yields to a same-port R to keep data_ok single-pulse.
    always_comb begin
        w_state_nxt = w_state;
        bready      = 1'b0;
        case (w_state)
            W_IDLE: if (wr_take) w_state_nxt = W_ADDR;
            W_ADDR: if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) w_state_nxt = W_RESP;
            W_RESP: begin
                bready = !reset && !(rvalid && (rid == 4'(wr_q.port)));
                if (b_hs) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            w_state  <= W_IDLE;
        end else begin
            ar_state <= ar_state_nxt;
            w_state  <= w_state_nxt;
        end
    end

    // Request latches, pointers, AW/W pending flags, counters and responses.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_q         <= '0;
            wr_q         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            aw_pend      <= 1'b0;
            w_pend       <= 1'b0;
            rd_cnt       <= '0;
            port_data_ok <= '0;
            port_rdata   <= '0;
        end else begin
            if (rd_take) begin
                rd_q   <= rd_sel;
                rd_ptr <= rr_next(rd_sel.port, NUM_PORTS);
            end
            if (wr_take) begin
                wr_q    <= wr_sel;
                wr_ptr  <= rr_next(wr_sel.port, NUM_PORTS);
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
            end else begin
                if (aw_hs) aw_pend <= 1'b0;
                if (w_hs)  w_pend  <= 1'b0;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                case ({rd_gnt[i], r_hit[i]})
                    2'b10:   rd_cnt[i] <= rd_cnt[i] + 1'b1;
                    2'b01:   rd_cnt[i] <= rd_cnt[i] - 1'b1;
                    default: rd_cnt[i] <= rd_cnt[i];
                endcase
            end
            port_data_ok <= r_hit | b_hit;
            if (|r_hit) port_rdata <= rdata;
        end
    end

    assign arid    = 4'(rd_q.port);
    assign araddr  = rd_q.addr;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = {1'b0, rd_q.size};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

    assign awid    = 4'(wr_q.port);
    assign awaddr  = wr_q.addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = {1'b0, wr_q.size};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NORMAL;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;
    assign awvalid = aw_pend;

    assign wid     = 4'(wr_q.port);
    assign wdata   = wr_q.wdata;
    assign wstrb   = wr_q.wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = w_pend;

endmodule

// File: tb/tb_multi_port_axi_bridge.sv
// Directed bench for multi_port_axi_bridge (2 ports, 2 outstanding reads).
module tb_multi_port_axi_bridge;

    localparam int NP = 2;

    logic                 aclk = 1'b0;
    logic                 reset;
    logic [NP-1:0]        port_req, port_wr;
    logic [NP-1:0][1:0]   port_size;
    logic [NP-1:0][31:0]  port_addr, port_wdata;
    logic [NP-1:0][3:0]   port_wstrb;
    logic [NP-1:0]        port_addr_ok, port_data_ok;
    logic [31:0]          port_rdata;
    logic [3:0]           arid, awid, wid, rid, bid;
    logic [31:0]          araddr, awaddr, wdata, rdata;
    logic [7:0]           arlen, awlen;
    logic [2:0]           arsize, awsize, arprot, awprot;
    logic [1:0]           arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]           arcache, awcache, wstrb;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    multi_port_axi_bridge #(.NUM_PORTS(NP), .RD_DEPTH(2)) dut (
        .aclk(aclk), .reset(reset),
        .port_req(port_req), .port_wr(port_wr), .port_size(port_size),
        .port_addr(port_addr), .port_wdata(port_wdata), .port_wstrb(port_wstrb),
        .port_addr_ok(port_addr_ok), .port_data_ok(port_data_ok), .port_rdata(port_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic look();
        #1;
    endtask

    logic [NP-1:0] exp_rr [10];
    logic [3:0]    drain_id [4];

    initial begin
        exp_rr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        drain_id = '{4'd0, 4'd0, 4'd1, 4'd1};

        reset = 1'b1;
        port_req = '0; port_wr = '0; port_size = '0;
        port_addr = '0; port_wdata = '0; port_wstrb = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;

        // Reset state, with requests present to show addr_ok stays low.
        port_req = 2'b11;
        tick(); tick(); look();
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_addr_ok", port_addr_ok, 0);
        check("rst_data_ok", port_data_ok, 0);
        check("rst_rdata", port_rdata, 0);
        port_req = '0;
        reset = 1'b0;
        tick(); look();
        check("rready_on", rready, 1);

        // Single read on port 0.
        arready = 1'b1;
        port_req = 2'b01; port_wr = 2'b00;
        port_addr[0] = 32'h1C00_0000; port_size[0] = 2'd2;
        look();
        check("rd0_addr_ok", port_addr_ok, 2'b01);
        tick();
        port_req = '0;
        look();
        check("rd0_arvalid", arvalid, 1);
        check("rd0_araddr", araddr, 32'h1C00_0000);
        check("rd0_arid", arid, 0);
        check("rd0_arsize", arsize, 2);
        check("rd0_arlen", arlen, 0);
        check("rd0_arburst", arburst, 1);
        check("rd0_lock_cache_prot", {arlock, arcache, arprot}, 0);
        tick(); look();
        check("rd0_arvalid_drop", arvalid, 0);
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
        look();
        check("rd0_no_early_ok", port_data_ok, 0);
        tick();
        rvalid = 1'b0;
        look();
        check("rd0_data_ok", port_data_ok, 2'b01);
        check("rd0_rdata", port_rdata, 32'hDEAD_BEEF);
        tick(); look();
        check("rd0_data_ok_pulse", port_data_ok, 0);

        // Reset while AR is pending: abandoned, stale R ignored.
        arready = 1'b0;
        port_req = 2'b01; port_addr[0] = 32'h0000_2000;
        tick();
        port_req = '0;
        look();
        check("mid_arvalid", arvalid, 1);
        reset = 1'b1;
        tick(); look();
        check("mid_arvalid_clr", arvalid, 0);
        reset = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hBAD0_BAD0;
        tick();
        rvalid = 1'b0;
        look();
        check("mid_no_data_ok", port_data_ok, 0);
        tick(); look();
        check("mid_no_data_ok2", port_data_ok, 0);
        check("mid_rdata_kept", port_rdata, 0);

        // Two ports reading continuously: alternate grants, stall at depth 2.
        arready = 1'b1;
        port_addr[0] = 32'h0000_1000; port_addr[1] = 32'h0000_2000;
        port_size[0] = 2'd2; port_size[1] = 2'd2;
        port_req = 2'b11; port_wr = 2'b00;
        for (int c = 0; c < 10; c++) begin
            look();
            check($sformatf("rr_cyc%0d", c), port_addr_ok, exp_rr[c]);
            tick();
        end
        port_req = '0;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rid = drain_id[k]; rdata = 32'hA0 + 32'(k);
            tick(); look();
            check($sformatf("rr_drain_ok%0d", k), port_data_ok, (drain_id[k] == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_drain_rd%0d", k), port_rdata, 32'hA0 + 32'(k));
        end
        rvalid = 1'b0;
        tick(); look();
        check("rr_drain_quiet", port_data_ok, 0);

        // Port 1 write; AW accepted two cycles before W.
        awready = 1'b0; wready = 1'b0;
        port_req = 2'b10; port_wr = 2'b10;
        port_addr[1] = 32'h0000_0100; port_wdata[1] = 32'h1234_5678;
        port_wstrb[1] = 4'hF; port_size[1] = 2'd2;
        look();
        check("wr1_addr_ok", port_addr_ok, 2'b10);
        tick();
        port_req = '0;
        look();
        check("wr1_awvalid", awvalid, 1);
        check("wr1_wvalid", wvalid, 1);
        check("wr1_awaddr", awaddr, 32'h100);
        check("wr1_awid", awid, 1);
        check("wr1_wid", wid, 1);
        check("wr1_wdata", wdata, 32'h1234_5678);
        check("wr1_wstrb", wstrb, 4'hF);
        check("wr1_wlast", wlast, 1);
        check("wr1_awsize", awsize, 2);
        check("wr1_awlen_burst", {awlen, awburst}, 10'h001);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        look();
        check("wr1_aw_drop", awvalid, 0);
        check("wr1_w_hold", wvalid, 1);
        tick();
        wready = 1'b1;
        tick();
        wready = 1'b0;
        look();
        check("wr1_w_drop", wvalid, 0);
        check("wr1_bready", bready, 1);
        bvalid = 1'b1; bid = 4'd1;
        tick();
        bvalid = 1'b0;
        look();
        check("wr1_data_ok", port_data_ok, 2'b10);
        tick(); look();
        check("wr1_data_ok_pulse", port_data_ok, 0);
        check("wr1_bready_off", bready, 0);

        // RAW hazard: 0x104 passes, 0x103 waits for B on the 0x100 write.
        port_req = 2'b10; port_wr = 2'b10;
        look();
        check("raw_wr_addr_ok", port_addr_ok, 2'b10);
        tick();
        port_req = 2'b01; port_wr = 2'b00; port_addr[0] = 32'h0000_0104;
        look();
        check("raw_104_ok", port_addr_ok, 2'b01);
        tick();
        port_addr[0] = 32'h0000_0103;
        look();
        check("raw_104_araddr", araddr, 32'h104);
        tick(); look();
        check("raw_103_blocked", port_addr_ok, 0);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        look();
        check("raw_103_blocked_resp", port_addr_ok, 0);
        bvalid = 1'b1; bid = 4'd1;
        tick();
        bvalid = 1'b0;
        look();
        check("raw_b_data_ok", port_data_ok, 2'b10);
        check("raw_103_released", port_addr_ok, 2'b01);
        tick();
        port_req = '0;
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_1111 * 32'(k + 1);
            tick(); look();
            check($sformatf("raw_drain%0d", k), port_data_ok, 2'b01);
        end
        rvalid = 1'b0;

        // R and B for port 0 together: B deferred one cycle.
        port_req = 2'b01; port_wr = 2'b01;
        port_addr[0] = 32'h0000_0200; port_wdata[0] = 32'h55; port_wstrb[0] = 4'h3;
        port_size[0] = 2'd1;
        look();
        check("col_wr_addr_ok", port_addr_ok, 2'b01);
        awready = 1'b1; wready = 1'b1;
        tick();
        port_wr = 2'b00; port_addr[0] = 32'h0000_0300;
        look();
        check("col_rd_addr_ok", port_addr_ok, 2'b01);
        check("col_awsize", awsize, 1);
        check("col_wstrb", wstrb, 4'h3);
        tick();
        port_req = '0; awready = 1'b0; wready = 1'b0;
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_F00D;
        bvalid = 1'b1; bid = 4'd0;
        look();
        check("col_bready_defer", bready, 0);
        tick();
        rvalid = 1'b0;
        look();
        check("col_bready_back", bready, 1);
        check("col_r_data_ok", port_data_ok, 2'b01);
        check("col_r_rdata", port_rdata, 32'hCAFE_F00D);
        tick();
        bvalid = 1'b0;
        look();
        check("col_b_data_ok", port_data_ok, 2'b01);
        tick(); look();
        check("col_quiet", port_data_ok, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_port_axi_bridge.md
MULTI_PORT_AXI_BRIDGE -- requirements
Module: multi_port_axi_bridge

Interface
REQ-001 The block SHALL run on a single clock with a synchronous, active-high reset, named aclk and reset respectively.
REQ-002 Parameter NUM_PORTS, default 2, SHALL set the number of SRAM-like master ports (legal range 1..4).
REQ-003 Parameter RD_DEPTH, default 2, SHALL set the maximum outstanding reads per port (legal range 1..4).
REQ-004 aclk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 port_req  in  NUM_PORTS  per-port request.
REQ-007 port_wr  in  NUM_PORTS  per-port write(1)/read(0).
REQ-008 port_size  in  2*NUM_PORTS  per-port byte count log2 (0/1/2).
REQ-009 port_addr / port_wdata  in  32*NUM_PORTS each  per-port address / store data.
REQ-010 port_wstrb  in  4*NUM_PORTS  per-port byte enables.
REQ-011 port_addr_ok / port_data_ok  out  NUM_PORTS each  per-port request accepted / response done.
REQ-012 port_rdata  out  32  shared read data, qualified by port_data_ok.
REQ-013 AXI3 master: AR (arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid out; arready in), R (rid 4, rdata 32, rresp 2, rlast, rvalid in; rready out), AW (same widths as AR, out; awready in), W (wid 4, wdata 32, wstrb 4, wlast, wvalid out; wready in), B (bid 4, bresp 2, bvalid in; bready out).

Function
REQ-014 arlen/awlen SHALL be 0, arburst/awburst 2'b01, lock/cache/prot 0, wlast 1, arsize/awsize {1'b0,size}; rresp/bresp SHALL be ignored.
REQ-015 arid/awid/wid SHALL equal the granted port index; R/B responses SHALL be routed by rid/bid.
REQ-016 Read FSM states AR_IDLE, AR_BUSY: in AR_IDLE a round-robin grant among eligible read requests SHALL assert that port's addr_ok in the same cycle, latch address/size, go AR_BUSY with arvalid=1; on arvalid&&arready return to AR_IDLE (next grant earliest the following cycle).
REQ-017 A read is eligible only if its port counter < RD_DEPTH and addr[31:2] does not match the pending write address (RAW hazard block until B received).
REQ-018 Write FSM states W_IDLE, W_ADDR, W_RESP: in W_IDLE a round-robin grant among write requests, only when total outstanding reads = 0, SHALL assert addr_ok, latch addr/wdata/wstrb/size, assert awvalid and wvalid together; each SHALL drop independently on its own handshake; when both done go W_RESP; on B handshake return to W_IDLE.
REQ-019 Only one write SHALL be outstanding; read and write grants SHALL be independent and may occur in the same cycle for different ports.
REQ-020 Round-robin pointers (one per FSM) SHALL move to one past the granted port on each grant; reset pointer = port 0.
REQ-021 rready SHALL be 1 outside reset; on R handshake, port_data_ok[rid] and port_rdata SHALL be registered (latency 1 cycle after handshake), port counter decremented.
REQ-022 bready SHALL be 1 in W_RESP except when rvalid is high with rid equal to the writing port (B deferred, no data_ok collision); B handshake SHALL produce port_data_ok one cycle later.
REQ-023 Per-port counters SHALL increment on read addr_ok, decrement on read return, and stay unchanged when both coincide.
REQ-024 port_data_ok SHALL be a single-cycle pulse per response.

Reset
REQ-025 On reset: FSMs to AR_IDLE/W_IDLE, counters 0, arvalid/awvalid/wvalid 0, rready/bready 0, addr_ok/data_ok 0, port_rdata 0; reset mid-transaction SHALL abandon it without any further addr_ok/data_ok.

Structure
REQ-026 A shared package SHALL hold FSM state encodings, AXI constants (burst INCR, len 0, lock/cache/prot 0) and port-index width.
REQ-027 One sub-module rr_arbiter (request vector, pointer in, one-hot grant out) SHALL be instantiated twice (read, write).

Verification
REQ-028 Port0 read 0x1C000000, arready=1, rdata=0xDEADBEEF after 3 cycles -> addr_ok[0] same cycle, arid=0, data_ok[0] with rdata=0xDEADBEEF 1 cycle after R handshake.
REQ-029 Ports0/1 read continuously, arready=1 -> grants alternate 0,1,0,1; port stalls after RD_DEPTH=2 unreturned reads.
REQ-030 Port1 write 0x100 data 0x12345678 wstrb 0xF, awready 2 cycles before wready -> awvalid drops first, wvalid later, single B -> data_ok[1].
REQ-031 Pending write 0x100 plus port0 read 0x103 -> read blocked until B; read 0x104 -> accepted immediately.
REQ-032 rvalid(rid=0) and bvalid(bid=0) same cycle -> bready=0, R first, B next cycle, data_ok[0] twice in successive cycles.
REQ-033 reset asserted while arvalid=1 -> arvalid=0 next cycle, counters 0, no data_ok.
